// File: rtl/fechadura_ctrl_if.sv
// Shared payload types and the keypad/setup/bolt/display bundle of the lock controller.
//   senha_pac_t : 20 BCD digits, digits[0] is the most recent, 4'hF = empty
//   setup_pac_t : configuration register (alarm, relock time, passwords)
//   bcd_pac_t   : display digits BCD5..BCD0
// Modports: slave = lock controller, master = surrounding logic / bench.
package fechadura_pkg;

  localparam int unsigned DIGITS = 20;
  localparam int unsigned SEC_W  = 7;

  typedef struct packed {
    logic [DIGITS-1:0][3:0] digits;
  } senha_pac_t;

  typedef struct packed {
    logic             bip_status;
    logic [SEC_W-1:0] bip_time;
    logic [SEC_W-1:0] tranca_aut_time;
    senha_pac_t       senha_master;
    senha_pac_t       senha_1;
    senha_pac_t       senha_2;
    senha_pac_t       senha_3;
    senha_pac_t       senha_4;
  } setup_pac_t;

  typedef struct packed {
    logic [5:0][3:0] bcd;
  } bcd_pac_t;

  typedef enum logic [2:0] {
    TRAVADA,
    DESTRAVADA,
    PORTA_ABERTA,
    SETUP,
    BLOQUEIO
  } state_t;

endpackage

interface fechadura_if;
  import fechadura_pkg::*;

  senha_pac_t digitos_value;
  logic       digitos_valid;
  logic       sensor_contato;
  logic       botao_interno;
  setup_pac_t data_setup_new;
  logic       data_setup_ok;
  logic       tranca;
  logic       bip;
  logic       setup_on;
  logic       display_en;
  bcd_pac_t   bcd_pac;

  modport slave (
    input  digitos_value, digitos_valid, sensor_contato, botao_interno,
           data_setup_new, data_setup_ok,
    output tranca, bip, setup_on, display_en, bcd_pac
  );

  modport master (
    output digitos_value, digitos_valid, sensor_contato, botao_interno,
           data_setup_new, data_setup_ok,
    input  tranca, bip, setup_on, display_en, bcd_pac
  );

endinterface

// File: rtl/fechadura_ctrl.sv
// Operating controller of the electronic lock: password check, bolt drive,
// auto-relock, door-open alarm, lockout after wrong entries, setup sequencing.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : fechadura_if.slave (keypad entry, door sensor, inside button,
//          setup data in; tranca, bip, setup_on, display_en, bcd_pac out)
module fechadura_ctrl
  import fechadura_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 1000,
  parameter int unsigned MAX_TENTATIVAS = 3,
  parameter int unsigned TEMPO_BLOQUEIO = 30
) (
  input  logic       clk,
  input  logic       rst,
  fechadura_if.slave bus
);

  localparam int unsigned PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned ERR_W = 3;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);
  localparam logic [SEC_W-1:0] SEC_MAX  = SEC_W'(99);
  localparam logic [SEC_W-1:0] TEMPO_S  = SEC_W'(TEMPO_BLOQUEIO);
  localparam logic [ERR_W-1:0] MAX_ERR  = ERR_W'(MAX_TENTATIVAS);

  localparam logic [DIGITS*4-1:0] ALL_E = {DIGITS{4'hE}};
  localparam logic [DIGITS*4-1:0] ALL_B = {DIGITS{4'hB}};
  localparam logic [DIGITS*4-1:0] ALL_F = {DIGITS{4'hF}};

  localparam senha_pac_t MASTER_RST = senha_pac_t'({{(DIGITS-4){4'hF}}, 16'h1234});

  localparam setup_pac_t CFG_RST = '{
    bip_status:      1'b1,
    bip_time:        SEC_W'(5),
    tranca_aut_time: SEC_W'(5),
    senha_master:    MASTER_RST,
    senha_1:         senha_pac_t'(ALL_F),
    senha_2:         senha_pac_t'(ALL_F),
    senha_3:         senha_pac_t'(ALL_F),
    senha_4:         senha_pac_t'(ALL_F)
  };

  state_t           state, state_nxt;
  logic [ERR_W-1:0] err_cnt, err_nxt;
  logic [PRE_W-1:0] prescaler, prescaler_nxt;
  logic [SEC_W-1:0] seconds, seconds_nxt;
  setup_pac_t       cfg;

  logic     tranca_nxt, bip_nxt, setup_on_nxt, display_en_nxt;
  bcd_pac_t bcd_nxt;

  // An all-F stored password is disabled and never matches
  function automatic logic senha_match(input senha_pac_t s, input senha_pac_t e);
    return (s != senha_pac_t'(ALL_F)) && (s == e);
  endfunction

  logic             entry_c, short_c, master_hit_c, user_hit_c, tick_c;
  logic [SEC_W-1:0] sec_inc_c, remaining_c;

  // Entry qualification and password comparison in the acceptance cycle
  always_comb begin
    entry_c      = bus.digitos_valid &&
                   (bus.digitos_value != senha_pac_t'(ALL_E)) &&
                   (bus.digitos_value != senha_pac_t'(ALL_B));
    short_c      = (bus.digitos_value.digits[3] == 4'hF);
    master_hit_c = !short_c && senha_match(cfg.senha_master, bus.digitos_value);
    user_hit_c   = !short_c && (senha_match(cfg.senha_1, bus.digitos_value) ||
                                senha_match(cfg.senha_2, bus.digitos_value) ||
                                senha_match(cfg.senha_3, bus.digitos_value) ||
                                senha_match(cfg.senha_4, bus.digitos_value));
  end

  // Timeouts compare against the count the seconds register is about to take,
  // so the transition lands on the very edge the count is reached
  always_comb begin
    tick_c    = (prescaler == PRE_LAST);
    sec_inc_c = (tick_c && (seconds != SEC_MAX)) ? seconds + SEC_W'(1) : seconds;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= TRAVADA;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and error-count logic
  always_comb begin
    state_nxt = state;
    err_nxt   = err_cnt;
    unique case (state)
      TRAVADA: begin
        if (bus.botao_interno) begin
          state_nxt = DESTRAVADA;
        end else if (entry_c) begin
          if (master_hit_c) begin
            state_nxt = SETUP;
            err_nxt   = '0;
          end else if (user_hit_c) begin
            state_nxt = DESTRAVADA;
            err_nxt   = '0;
          end else begin
            err_nxt = err_cnt + ERR_W'(1);
            if (err_nxt == MAX_ERR) state_nxt = BLOQUEIO;
          end
        end
      end
      DESTRAVADA: begin
        if (!bus.sensor_contato)                   state_nxt = PORTA_ABERTA;
        else if (bus.botao_interno)                state_nxt = TRAVADA;
        else if (sec_inc_c == cfg.tranca_aut_time) state_nxt = TRAVADA;
      end
      PORTA_ABERTA: begin
        if (bus.sensor_contato) state_nxt = DESTRAVADA;
      end
      SETUP: begin
        if (bus.data_setup_ok) state_nxt = TRAVADA;
      end
      BLOQUEIO: begin
        if (sec_inc_c == TEMPO_S) begin
          state_nxt = TRAVADA;
          err_nxt   = '0;
        end else if (bus.botao_interno) begin
          state_nxt = DESTRAVADA;
          err_nxt   = '0;
        end
      end
      default: state_nxt = TRAVADA;
    endcase
  end

  // Timer restarts on every state change
  always_comb begin
    prescaler_nxt = tick_c ? '0 : prescaler + PRE_W'(1);
    seconds_nxt   = sec_inc_c;
    if (state_nxt != state) begin
      prescaler_nxt = '0;
      seconds_nxt   = '0;
    end
  end

  // Output decode from the upcoming state so outputs change on the transition edge
  always_comb begin
    tranca_nxt     = 1'b1;
    bip_nxt        = 1'b0;
    setup_on_nxt   = 1'b0;
    display_en_nxt = 1'b0;
    bcd_nxt        = bcd_pac_t'({6{4'hF}});
    remaining_c    = (seconds_nxt >= TEMPO_S) ? '0 : TEMPO_S - seconds_nxt;
    unique case (state_nxt)
      DESTRAVADA: tranca_nxt = 1'b0;
      PORTA_ABERTA: begin
        tranca_nxt = 1'b0;
        bip_nxt    = cfg.bip_status && (seconds_nxt >= cfg.bip_time);
      end
      SETUP: setup_on_nxt = (state == TRAVADA);
      BLOQUEIO: begin
        display_en_nxt = 1'b1;
        bcd_nxt        = bcd_pac_t'({16'hFFFF,
                                     4'(remaining_c / SEC_W'(10)),
                                     4'(remaining_c % SEC_W'(10))});
      end
      default: tranca_nxt = 1'b1;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt        <= '0;
      prescaler      <= '0;
      seconds        <= '0;
      cfg            <= CFG_RST;
      bus.tranca     <= 1'b1;
      bus.bip        <= 1'b0;
      bus.setup_on   <= 1'b0;
      bus.display_en <= 1'b0;
      bus.bcd_pac    <= bcd_pac_t'({6{4'hF}});
    end else begin
      err_cnt        <= err_nxt;
      prescaler      <= prescaler_nxt;
      seconds        <= seconds_nxt;
      if (state == SETUP && bus.data_setup_ok) cfg <= bus.data_setup_new;
      bus.tranca     <= tranca_nxt;
      bus.bip        <= bip_nxt;
      bus.setup_on   <= setup_on_nxt;
      bus.display_en <= display_en_nxt;
      bus.bcd_pac    <= bcd_nxt;
    end
  end

endmodule

// File: doc/fechadura_ctrl.md
Name: fechadura_ctrl

Overview:
- Top-level operating controller of the electronic lock.
- Compares keypad entries against the stored user and master passwords, and drives the bolt (`tranca`).
- Times auto-relock and the door-open alarm, and enforces lockout after repeated wrong entries.
- Sequences the setup block: pulses `setup_on` after a master-password match, then latches the returned configuration on `data_setup_ok`.

Parameters:
- CLK_HZ, 1000: clock cycles per one-second tick (prescaler terminal count).
- MAX_TENTATIVAS, 3: consecutive wrong entries that trigger lockout; range 1..7.
- TEMPO_BLOQUEIO, 30: lockout duration in seconds; range 1..99.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, reset is synchronous and active-high
- digitos_value  in  senhaPac_t (80)  keypad entry; digits[0] is the most recent digit; 4'hF = empty
- digitos_valid  in  1  entry-complete strobe, 1 cycle
- sensor_contato  in  1  1 = door closed
- botao_interno  in  1  inside push-button, synchronised, 1-cycle pulse
- data_setup_new  in  setupPac_t  configuration from the setup block
- data_setup_ok  in  1  configuration valid strobe
- tranca  out  1  1 = bolt engaged
- bip  out  1  door-open alarm
- setup_on  out  1  1-cycle pulse that starts the setup block
- display_en  out  1  this block owns the display
- bcd_pac  out  bcdPac_t  display digits BCD5..BCD0

Behaviour:
- Reset (synchronous): state TRAVADA, tranca=1, bip=0, setup_on=0, display_en=0, all BCD=4'hF.
  - Error count 0; prescaler and seconds counter 0.
  - Config register: bip_status=1, bip_time=5, tranca_aut_time=5.
  - senha_master digits[3:0]=1,2,3,4 (entry "1234"), rest F; senha_1..4 all F.
- Entry acceptance:
  - An entry is considered only when digitos_valid=1.
  - All-4'hE and all-4'hB entries are ignored.
  - An entry with digits[3]==F (fewer than 4 digits) counts as wrong.
- Match rule, stored password S vs entry E:
  - S all-F = disabled, never matches.
  - Otherwise match iff E.digits[i]==S.digits[i] for every i in 0..19.
  - Checked combinationally in the acceptance cycle.
- Timer:
  - Prescaler counts 0..CLK_HZ-1; tick at terminal count; seconds counter increments on tick, saturating at 99.
  - Both clear on every state transition.
- States:
  - TRAVADA: tranca=1.
    - Priority: botao_interno → DESTRAVADA.
    - Else valid entry matching master → SETUP; setup_on=1 in the transition cycle only; error count cleared.
    - Else match with senha_1..4 → DESTRAVADA; error count cleared.
    - Else error count +1; if the new count == MAX_TENTATIVAS → BLOQUEIO.
  - DESTRAVADA: tranca=0.
    - sensor_contato=0 → PORTA_ABERTA.
    - Else botao_interno → TRAVADA.
    - Else seconds == tranca_aut_time → TRAVADA.
    - Keypad entries are ignored.
  - PORTA_ABERTA: tranca=0.
    - bip=1 while bip_status=1 and seconds >= bip_time.
    - sensor_contato=1 → DESTRAVADA (timer restarts, bip drops same cycle as state change).
  - SETUP: tranca=1; keypad ignored by this block.
    - data_setup_ok=1 → latch data_setup_new into config register, → TRAVADA.
    - A door opening during SETUP has no effect.
  - BLOQUEIO: tranca=1; keypad ignored.
    - display_en=1; BCD1/BCD0 = tens/units of (TEMPO_BLOQUEIO − seconds); BCD5..BCD2=F.
    - seconds == TEMPO_BLOQUEIO → TRAVADA, error count cleared.
    - botao_interno → DESTRAVADA, error count cleared (escape from inside).
- Outputs: registered, updated on the state-transition edge. display_en=0 and BCD=F outside BLOQUEIO.
- Simultaneous botao_interno and digitos_valid in TRAVADA: the button wins; the entry is discarded and not counted.
- rst asserted mid-operation: the config register returns to defaults, so non-volatile storage is outside this block.

Test Plan (CLK_HZ=10):
- Reset, enter 1,2,3,4 (digits[3:0]=1,2,3,4) → setup_on high exactly 1 cycle, tranca=1. Then data_setup_ok with senha_1="5678", tranca_aut_time=7 → TRAVADA.
- After the previous case, entry "5678" → tranca=0 next cycle. Door stays closed → tranca=1 exactly 70 cycles later.
- Unlock with "5678", sensor_contato=0 → after 50 cycles bip=1. sensor_contato=1 → bip=0; relock after the auto time.
- Three wrong entries ("9999", "12", "0000") → BLOQUEIO, display_en=1, BCD1/BCD0=3/0, decrements each 10 cycles. After 300 cycles → TRAVADA, display_en=0, and "1234" is again accepted.
- In BLOQUEIO, enter the correct user password → ignored. botao_interno → tranca=0, error count 0.
- Same-cycle botao_interno and a wrong entry in TRAVADA → DESTRAVADA, error count unchanged. Assert rst in PORTA_ABERTA with bip=1 → next cycle tranca=1, bip=0, master reverts to "1234".
